// File: rtl/rvm_mem_sequencer.sv
// rtl/rvm_mem_sequencer.sv - single-request memory access sequencer with alignment checks and stall timeout
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake; req_op, req_size, req_signed, req_addr, req_wdata
//   rsp_valid/rsp_ready         response handshake; rsp_rdata (extended data), rsp_err (00 ok, 01 align, 10 bus, 11 timeout)
//   mem_addr, mem_wdata         lane-aligned address and replicated store data
//   mem_c_en, mem_w_en, mem_b_en chip, write and byte-lane enables
//   mem_rdata, mem_error, mem_stall memory read data, bus error, not-yet-complete
module rvm_mem_sequencer #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              mem_c_en,
  output logic              mem_w_en,
  output logic [XLEN/8-1:0] mem_b_en,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_error,
  input  logic              mem_stall
);

  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic            store_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [OB-1:0]   off_q;
  logic [CW-1:0]   cnt;

  logic [1:0]      eff_size;
  logic            eff_signed;
  logic            req_bad;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] wrep;
  logic [XLEN-1:0] rd_ext;

  // Fetches are always unsigned word accesses regardless of size/signed inputs.
  assign eff_size   = (req_op == 2'b00) ? 2'b10 : req_size;
  assign eff_signed = (req_op != 2'b00) & req_signed;

  always_comb begin
    req_bad = 1'b0;
    case (eff_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = |req_addr[1:0];
      default: req_bad = (XLEN == 32) | (|req_addr[2:0]);
    endcase
  end

  always_comb begin
    size_mask = '0;
    case (eff_size)
      2'b00:   size_mask = NB'(8'h01);
      2'b01:   size_mask = NB'(8'h03);
      2'b10:   size_mask = NB'(8'h0F);
      default: size_mask = NB'(8'hFF);
    endcase
  end

  // Replicate the right-justified store datum across every lane so the
  // memory sees it regardless of which byte enables are active.
  always_comb begin
    wrep = '0;
    for (int i = 0; i < NB; i++) begin
      case (eff_size)
        2'b00:   wrep[8*i +: 8] = req_wdata[7:0];
        2'b01:   wrep[8*i +: 8] = req_wdata[8*(i%2) +: 8];
        2'b10:   wrep[8*i +: 8] = req_wdata[8*(i%4) +: 8];
        default: wrep[8*i +: 8] = req_wdata[8*(i%8) +: 8];
      endcase
    end
  end

  function automatic logic [XLEN-1:0] extend_rd(input logic [XLEN-1:0] d,
                                                input logic [1:0]      sz,
                                                input logic            sg);
    int              w;
    logic [XLEN-1:0] keep;
    logic            fill;
    w = 8 << sz;
    if (w > XLEN) w = XLEN;
    keep = (w >= XLEN) ? '1 : ((XLEN'(1) << w) - XLEN'(1));
    fill = sg & (|(d & (XLEN'(1) << (w - 1))));
    return (d & keep) | ({XLEN{fill}} & ~keep);
  endfunction

  assign rd_ext = extend_rd(mem_rdata >> {off_q, 3'b000}, size_q, signed_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_c_en  <= 1'b0;
      mem_w_en  <= 1'b0;
      mem_b_en  <= '0;
      store_q   <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      off_q     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            store_q   <= (req_op == 2'b10);
            size_q    <= eff_size;
            signed_q  <= eff_signed;
            off_q     <= req_addr[OB-1:0];
            if (req_bad) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 2'b01;
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              cnt       <= '0;
              mem_c_en  <= 1'b1;
              mem_w_en  <= (req_op == 2'b10);
              mem_addr  <= {req_addr[XLEN-1:OB], {OB{1'b0}}};
              mem_b_en  <= size_mask << req_addr[OB-1:0];
              mem_wdata <= (req_op == 2'b10) ? wrep : '0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Completion is checked before the timeout so a stall release on
          // the limit cycle still returns the memory result.
          if (!mem_stall) begin
            rsp_valid <= 1'b1;
            rsp_err   <= mem_error ? 2'b10 : 2'b00;
            rsp_rdata <= (mem_error || store_q) ? '0 : rd_ext;
            mem_c_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            mem_b_en  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt == LIMIT) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b11;
            rsp_rdata <= '0;
            mem_c_en  <= 1'b0;
            mem_w_en  <= 1'b0;
            mem_b_en  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 2'b00;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
